// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared widths, state type and digit check for bcd_to_bin
package bcd_to_bin_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int BIN_W      = 12;
  localparam int ITERATIONS = 12;
  localparam int BCD_W      = NUM_DIGITS * DIGIT_W;
  localparam int SR_W       = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic has_invalid_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one BCD digit correction step: subtract 3 when the digit is >= 8
module bcd_digit_adj
  import bcd_to_bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential reverse double-dabble BCD to binary converter
module bcd_to_bin
  import bcd_to_bin_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        busy,
  output logic        done,
  output logic [11:0] binary,
  output logic        err
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]  binary_q, binary_d;
  logic              err_q, err_d;
  logic              invalid_q, invalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   iter;
  logic [BCD_W-1:0]  adj_bcd;

  assign shifted = sr_q >> 1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dout (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign iter = {adj_bcd, shifted[BIN_W-1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    binary_d  = binary_q;
    err_d     = err_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          sr_d      = {hundreds, tens, ones, {BIN_W{1'b0}}};
          cnt_d     = 4'd0;
          invalid_d = has_invalid_digit({hundreds, tens, ones});
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        sr_d  = iter;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITERATIONS - 1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          // Valid results never exceed 999, so the top two bits are forced clear.
          binary_d = invalid_q ? '0 : {2'b00, iter[BIN_W-3:0]};
          err_d    = invalid_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= '0;
      binary_q  <= '0;
      err_q     <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      binary_q  <= binary_d;
      err_q     <= err_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - scoreboard bench for bcd_to_bin
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  hundreds, tens, ones;
  logic        busy, done, err;
  logic [11:0] binary;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] bin;
    logic        err;
    int          when;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  logic done_prev = 1'b0;

  bcd_to_bin dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .busy     (busy),
    .done     (done),
    .binary   (binary),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done && done_prev) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_twice: done high two cycles in a row at cyc %0d", cyc);
    end
    done_prev = done;
    if (done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: cyc %0d binary %0d err %0b, nothing expected", cyc, binary, err);
      end else begin
        e_mon = sb.pop_front();
        if (binary !== e_mon.bin || err !== e_mon.err || cyc != e_mon.when) begin
          n_fail++;
          $display("FAIL %s: got binary %0d err %0b cyc %0d, expected binary %0d err %0b cyc %0d",
                   e_mon.name, binary, err, cyc, e_mon.bin, e_mon.err, e_mon.when);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input string name, input logic [11:0] bin, input logic e, input int when);
    exp_t x;
    x.bin  = bin;
    x.err  = e;
    x.when = when;
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  // Called at a negedge with the DUT idle; the expected result is supplied by the caller.
  task automatic convert(input string name, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input logic [11:0] bin, input logic e);
    hundreds = h;
    tens     = t;
    ones     = o;
    start    = 1'b1;
    expect_result(name, bin, e, cyc + 13);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    wait_idle(name);
    @(negedge clk);
  endtask

  initial begin
    int c0;
    reset    = 1'b1;
    start    = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_binary", binary, 0);
    check("reset_err", err, 0);

    convert("d999", 4'd9, 4'd9, 4'd9, 12'h3E7, 1'b0);
    repeat (5) @(negedge clk);
    check("hold_binary", binary, 999);
    convert("d405", 4'd4, 4'd0, 4'd5, 12'h195, 1'b0);
    convert("d000", 4'd0, 4'd0, 4'd0, 12'd0, 1'b0);
    convert("bad_tens", 4'd0, 4'd10, 4'd5, 12'd0, 1'b1);
    convert("d123", 4'd1, 4'd2, 4'd3, 12'd123, 1'b0);
    convert("bad_hund", 4'd15, 4'd0, 4'd0, 12'd0, 1'b1);
    convert("d090", 4'd0, 4'd9, 4'd0, 12'd90, 1'b0);

    // start held high: one conversion every 14 cycles
    hundreds = 4'd2;
    tens     = 4'd5;
    ones     = 4'd6;
    start    = 1'b1;
    c0       = cyc;
    expect_result("held_1", 12'd256, 1'b0, c0 + 13);
    expect_result("held_2", 12'd256, 1'b0, c0 + 27);
    expect_result("held_3", 12'd256, 1'b0, c0 + 41);
    repeat (41) @(negedge clk);
    start = 1'b0;
    wait_idle("held");
    @(negedge clk);

    // Re-pulse with new digits during SHIFT must be ignored
    hundreds = 4'd7;
    tens     = 4'd7;
    ones     = 4'd7;
    start    = 1'b1;
    expect_result("d777", 12'd777, 1'b0, cyc + 13);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hundreds = 4'd1;
    tens     = 4'd1;
    ones     = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("d777");
    @(negedge clk);

    // Reset in the 6th SHIFT cycle aborts without a done pulse
    hundreds = 4'd8;
    tens     = 4'd8;
    ones     = 4'd8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_binary", binary, 0);
    check("abort_err", err, 0);
    repeat (15) @(negedge clk);
    check("abort_no_done_busy", busy, 0);
    convert("d314", 4'd3, 4'd1, 4'd4, 12'd314, 1'b0);

    for (int h = 0; h < 10; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 10; o++) begin
          convert("sweep", 4'(h), 4'(t), 4'(o), 12'(h * 100 + t * 10 + o), 1'b0);
        end
      end
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
